// File: rtl/dag_pkg.sv
// Shared definitions for the data address generator: default sizes,
// register type codes and helpers that slice a register address
// {type, bank, idx} into its fields.
package dag_pkg;

    localparam int DAG_AW    = 16;
    localparam int DAG_NREG  = 8;
    localparam int DAG_NBANK = 2;

    typedef enum logic [1:0] {
        REG_M = 2'b00,
        REG_I = 2'b01,
        REG_L = 2'b10,
        REG_B = 2'b11
    } reg_type_e;

    // Type field sits above the bank and index fields.
    function automatic logic [1:0] raw_type(input int unsigned add,
                                            input int unsigned iw,
                                            input int unsigned bw);
        int unsigned sh;
        sh = add >> (iw + bw);
        return sh[1:0];
    endfunction

    // Bank field sits directly above the index field.
    function automatic int unsigned raw_bank(input int unsigned add,
                                             input int unsigned iw,
                                             input int unsigned bw);
        return (add >> iw) & ((32'd1 << bw) - 32'd1);
    endfunction

    // Index field occupies the low bits.
    function automatic int unsigned raw_idx(input int unsigned add,
                                            input int unsigned iw);
        return add & ((32'd1 << iw) - 32'd1);
    endfunction

endpackage

// File: rtl/dag_circ_mod.sv
// Combinational modify unit: I + M with optional circular wrap inside
// the buffer [B, B+L). L == 0 selects plain linear addressing.
module dag_circ_mod
    import dag_pkg::*;
#(
    parameter int AW = DAG_AW
) (
    input  logic [AW-1:0] i,
    input  logic [AW-1:0] m,
    input  logic [AW-1:0] l,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] res
);

    logic [AW-1:0] sum;
    logic [AW-1:0] top;

    // Single wrap only: |M| < L keeps the result inside the buffer.
    always_comb begin
        sum = i + m;
        top = b + l;
        res = sum;
        if (l != '0) begin
            if (!m[AW-1]) begin
                if (sum >= top) res = sum - l;
            end else begin
                if (sum < b) res = sum + l;
            end
        end
    end

endmodule

// File: rtl/dag_circ.sv
// Data address generator with circular buffering. Holds NBANK banks of
// I/M/L/B registers, serves one address request per cycle and emits a
// registered address per bank (bank 0 -> dm bus, bank 1 -> ps bus).
module dag_circ
    import dag_pkg::*;
#(
    parameter int AW    = DAG_AW,
    parameter int NREG  = DAG_NREG,
    parameter int NBANK = DAG_NBANK,
    parameter int RAW   = 2 + $clog2(NBANK * NREG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps_dg_en,
    input  logic [$clog2(NBANK)-1:0] ps_dg_dgsclt,
    input  logic                     ps_dg_mdfy,
    input  logic [$clog2(NREG)-1:0]  ps_dg_iadd,
    input  logic [$clog2(NREG)-1:0]  ps_dg_madd,
    input  logic                     ps_dg_wrt_en,
    input  logic [RAW-1:0]           ps_dg_wrt_add,
    input  logic [RAW-1:0]           ps_dg_rd_add,
    input  logic [AW-1:0]            bc_dt,
    output logic [AW-1:0]            dg_dm_add,
    output logic [AW-1:0]            dg_ps_add,
    output logic                     dg_dm_vld,
    output logic                     dg_ps_vld,
    output logic [AW-1:0]            dg_bc_dt
);

    localparam int IW = $clog2(NREG);
    localparam int BW = $clog2(NBANK);

    logic [AW-1:0] m_reg [NBANK][NREG];
    logic [AW-1:0] i_reg [NBANK][NREG];
    logic [AW-1:0] l_reg [NBANK][NREG];
    logic [AW-1:0] b_reg [NBANK][NREG];

    reg_type_e     wr_type, rd_type;
    logic [BW-1:0] wr_bank, rd_bank;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          wr_ok, rd_ok, req_ok;
    logic [AW-1:0] rd_val;

    logic [NBANK-1:0][AW-1:0] mod_res;
    logic [NBANK-1:0][AW-1:0] addr_out;
    logic [NBANK-1:0]         vld_out;

    // Decode write/read register addresses and qualify the request bank.
    always_comb begin
        wr_type = reg_type_e'(raw_type(32'(ps_dg_wrt_add), IW, BW));
        wr_bank = BW'(raw_bank(32'(ps_dg_wrt_add), IW, BW));
        wr_idx  = IW'(raw_idx(32'(ps_dg_wrt_add), IW));
        rd_type = reg_type_e'(raw_type(32'(ps_dg_rd_add), IW, BW));
        rd_bank = BW'(raw_bank(32'(ps_dg_rd_add), IW, BW));
        rd_idx  = IW'(raw_idx(32'(ps_dg_rd_add), IW));
        wr_ok   = ps_dg_wrt_en && (int'(wr_bank) < NBANK);
        rd_ok   = int'(rd_bank) < NBANK;
        req_ok  = ps_dg_en && (int'(ps_dg_dgsclt) < NBANK);
    end

    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
        logic          wr_here;
        logic [AW-1:0] op_i, op_m, op_l, op_b;
        logic [AW-1:0] addr_reg;
        logic          vld_reg;
        logic          req_here;

        assign wr_here  = wr_ok && (wr_bank == BW'(gi));
        assign req_here = req_ok && (ps_dg_dgsclt == BW'(gi));

        // Same-cycle writes forward bc_dt into the operands.
        assign op_i = (wr_here && wr_type == REG_I && wr_idx == ps_dg_iadd) ? bc_dt : i_reg[gi][ps_dg_iadd];
        assign op_m = (wr_here && wr_type == REG_M && wr_idx == ps_dg_madd) ? bc_dt : m_reg[gi][ps_dg_madd];
        assign op_l = (wr_here && wr_type == REG_L && wr_idx == ps_dg_iadd) ? bc_dt : l_reg[gi][ps_dg_iadd];
        assign op_b = (wr_here && wr_type == REG_B && wr_idx == ps_dg_iadd) ? bc_dt : b_reg[gi][ps_dg_iadd];

        dag_circ_mod #(.AW(AW)) u_mod (
            .i   (op_i),
            .m   (op_m),
            .l   (op_l),
            .b   (op_b),
            .res (mod_res[gi])
        );

        // Bank address register: load on request, hold otherwise; vld pulses.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                addr_reg <= '0;
                vld_reg  <= 1'b0;
            end else begin
                vld_reg <= req_here;
                if (req_here) addr_reg <= ps_dg_mdfy ? mod_res[gi] : op_i;
            end
        end

        assign addr_out[gi] = addr_reg;
        assign vld_out[gi]  = vld_reg;
    end

    assign dg_dm_add = addr_out[0];
    assign dg_ps_add = addr_out[1];
    assign dg_dm_vld = vld_out[0];
    assign dg_ps_vld = vld_out[1];

    // Register file update; explicit writes come last so they beat the
    // post-modify update of the same I.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int r = 0; r < NREG; r++) begin
                    m_reg[b][r] <= '0;
                    i_reg[b][r] <= '0;
                    l_reg[b][r] <= '0;
                    b_reg[b][r] <= '0;
                end
            end
        end else begin
            if (req_ok && !ps_dg_mdfy)
                i_reg[ps_dg_dgsclt][ps_dg_iadd] <= mod_res[ps_dg_dgsclt];
            if (wr_ok) begin
                case (wr_type)
                    REG_M: m_reg[wr_bank][wr_idx] <= bc_dt;
                    REG_I: i_reg[wr_bank][wr_idx] <= bc_dt;
                    REG_L: l_reg[wr_bank][wr_idx] <= bc_dt;
                    REG_B: begin
                        b_reg[wr_bank][wr_idx] <= bc_dt;
                        i_reg[wr_bank][wr_idx] <= bc_dt;
                    end
                endcase
            end
        end
    end

    // Combinational register read with bypass of a matching write.
    always_comb begin
        rd_val = '0;
        if (rd_ok) begin
            case (rd_type)
                REG_M: rd_val = m_reg[rd_bank][rd_idx];
                REG_I: rd_val = i_reg[rd_bank][rd_idx];
                REG_L: rd_val = l_reg[rd_bank][rd_idx];
                REG_B: rd_val = b_reg[rd_bank][rd_idx];
            endcase
        end
        dg_bc_dt = (ps_dg_wrt_en && ps_dg_wrt_add == ps_dg_rd_add) ? bc_dt : rd_val;
    end

endmodule

// File: tb/tb_dag_circ.sv
// Directed testbench for dag_circ with hand-computed expected addresses.
module tb_dag_circ;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps_dg_en = 1'b0;
    logic [0:0]  ps_dg_dgsclt = '0;
    logic        ps_dg_mdfy = 1'b0;
    logic [2:0]  ps_dg_iadd = '0;
    logic [2:0]  ps_dg_madd = '0;
    logic        ps_dg_wrt_en = 1'b0;
    logic [5:0]  ps_dg_wrt_add = '0;
    logic [5:0]  ps_dg_rd_add = '0;
    logic [15:0] bc_dt = '0;
    logic [15:0] dg_dm_add, dg_ps_add, dg_bc_dt;
    logic        dg_dm_vld, dg_ps_vld;

    int total = 0;
    int bad = 0;

    localparam logic [1:0] TM = 2'b00, TI = 2'b01, TL = 2'b10, TB = 2'b11;

    dag_circ dut (
        .clk           (clk),
        .rst           (rst),
        .ps_dg_en      (ps_dg_en),
        .ps_dg_dgsclt  (ps_dg_dgsclt),
        .ps_dg_mdfy    (ps_dg_mdfy),
        .ps_dg_iadd    (ps_dg_iadd),
        .ps_dg_madd    (ps_dg_madd),
        .ps_dg_wrt_en  (ps_dg_wrt_en),
        .ps_dg_wrt_add (ps_dg_wrt_add),
        .ps_dg_rd_add  (ps_dg_rd_add),
        .bc_dt         (bc_dt),
        .dg_dm_add     (dg_dm_add),
        .dg_ps_add     (dg_ps_add),
        .dg_dm_vld     (dg_dm_vld),
        .dg_ps_vld     (dg_ps_vld),
        .dg_bc_dt      (dg_bc_dt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    function automatic logic [5:0] ra(input logic [1:0] t, input logic b, input logic [2:0] i);
        return {t, b, i};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] t, input logic b, input logic [2:0] i, input logic [15:0] v);
        ps_dg_wrt_en  = 1'b1;
        ps_dg_wrt_add = ra(t, b, i);
        bc_dt         = v;
        tick();
        ps_dg_wrt_en  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] t, input logic b, input logic [2:0] i, input logic [15:0] exp);
        ps_dg_rd_add = ra(t, b, i);
        #1;
        chk(tag, 32'(dg_bc_dt), 32'(exp));
    endtask

    task automatic set_req(input logic b, input logic md, input logic [2:0] ia, input logic [2:0] ma);
        ps_dg_en     = 1'b1;
        ps_dg_dgsclt = b;
        ps_dg_mdfy   = md;
        ps_dg_iadd   = ia;
        ps_dg_madd   = ma;
    endtask

    logic [15:0] exp_fwd [4] = '{16'h0200, 16'h0202, 16'h0204, 16'h0201};
    logic [15:0] exp_neg [4] = '{16'h0040, 16'h0045, 16'h0042, 16'h0047};

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_dm_vld", 32'(dg_dm_vld), 0);
        chk("rst_dm_add", 32'(dg_dm_add), 0);
        rd("rst_rd_i0", TI, 1'b0, 3'd0, 16'h0000);

        // Linear post-modify, back-to-back on I0
        wr(TI, 1'b0, 3'd0, 16'h0100);
        wr(TM, 1'b0, 3'd0, 16'h0004);
        set_req(1'b0, 1'b0, 3'd0, 3'd0);
        tick(); chk("lin_add0", 32'(dg_dm_add), 32'h0100); chk("lin_vld0", 32'(dg_dm_vld), 1);
        tick(); chk("lin_add1", 32'(dg_dm_add), 32'h0104);
        tick(); chk("lin_add2", 32'(dg_dm_add), 32'h0108);
        ps_dg_en = 1'b0;
        tick(); chk("lin_vld_drop", 32'(dg_dm_vld), 0); chk("lin_hold", 32'(dg_dm_add), 32'h0108);
        rd("lin_i0", TI, 1'b0, 3'd0, 16'h010C);

        // Circular forward on bank 0 index 0
        wr(TL, 1'b0, 3'd0, 16'h0005);
        wr(TB, 1'b0, 3'd0, 16'h0200);
        wr(TM, 1'b0, 3'd0, 16'h0002);
        rd("cf_b_loads_i", TI, 1'b0, 3'd0, 16'h0200);
        set_req(1'b0, 1'b0, 3'd0, 3'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("cf_add%0d", k), 32'(dg_dm_add), 32'(exp_fwd[k]));
        end
        ps_dg_en = 1'b0;
        tick();
        rd("cf_i0", TI, 1'b0, 3'd0, 16'h0203);

        // Circular negative on bank 1 index 0
        wr(TL, 1'b1, 3'd0, 16'h0008);
        wr(TB, 1'b1, 3'd0, 16'h0040);
        wr(TM, 1'b1, 3'd0, 16'hFFFD);
        set_req(1'b1, 1'b0, 3'd0, 3'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("cn_add%0d", k), 32'(dg_ps_add), 32'(exp_neg[k]));
        end
        chk("cn_ps_vld", 32'(dg_ps_vld), 1);
        chk("cn_dm_vld", 32'(dg_dm_vld), 0);
        chk("cn_dm_hold", 32'(dg_dm_add), 32'h0201);
        ps_dg_en = 1'b0;
        tick();
        chk("cn_ps_vld_drop", 32'(dg_ps_vld), 0);

        // Pre-modify with same-cycle M write forwarded
        wr(TL, 1'b0, 3'd0, 16'h0000);
        wr(TI, 1'b0, 3'd0, 16'h0010);
        set_req(1'b0, 1'b1, 3'd0, 3'd2);
        ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = ra(TM, 1'b0, 3'd2); bc_dt = 16'h0008;
        tick();
        ps_dg_en = 1'b0; ps_dg_wrt_en = 1'b0;
        chk("pre_add", 32'(dg_dm_add), 32'h0018);
        rd("pre_i0_keep", TI, 1'b0, 3'd0, 16'h0010);
        rd("pre_m2", TM, 1'b0, 3'd2, 16'h0008);

        // Collision: post-modify on I3 with an explicit write to I3
        wr(TM, 1'b0, 3'd3, 16'h0010);
        wr(TI, 1'b0, 3'd3, 16'h0500);
        set_req(1'b0, 1'b0, 3'd3, 3'd3);
        ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = ra(TI, 1'b0, 3'd3); bc_dt = 16'h7000;
        ps_dg_rd_add = ra(TI, 1'b0, 3'd3);
        #1;
        chk("col_bypass", 32'(dg_bc_dt), 32'h7000);
        tick();
        chk("col_add", 32'(dg_dm_add), 32'h7000);
        // Parallel: post-modify I3 while writing I5
        ps_dg_wrt_add = ra(TI, 1'b0, 3'd5); bc_dt = 16'h1234;
        tick();
        ps_dg_en = 1'b0; ps_dg_wrt_en = 1'b0;
        chk("col_add2", 32'(dg_dm_add), 32'h7000);
        rd("col_i3", TI, 1'b0, 3'd3, 16'h7010);
        rd("par_i5", TI, 1'b0, 3'd5, 16'h1234);

        // Reset in the middle of a pending request
        set_req(1'b1, 1'b0, 3'd0, 3'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_dm_add", 32'(dg_dm_add), 0);
        chk("mid_rst_ps_add", 32'(dg_ps_add), 0);
        tick();
        ps_dg_en = 1'b0;
        rst = 1'b0;
        tick();
        chk("mid_rst_ps_vld", 32'(dg_ps_vld), 0);
        chk("mid_rst_dm_vld", 32'(dg_dm_vld), 0);
        rd("mid_rst_i3", TI, 1'b0, 3'd3, 16'h0000);
        rd("mid_rst_m0", TM, 1'b0, 3'd0, 16'h0000);
        rd("mid_rst_l1", TL, 1'b1, 3'd0, 16'h0000);
        rd("mid_rst_b1", TB, 1'b1, 3'd0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
